// File: rtl/nibble_add_scheduler.sv
// Two-requester wide adder that time-shares one 4-bit parallel_adder,
// rippling the carry through a register one nibble per cycle, LSB first.

module parallel_adder (
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic       carry_in,
  output logic [3:0] sum,
  output logic       carry_out
);
  assign {carry_out, sum} = 5'(in1) + 5'(in2) + 5'(carry_in);
endmodule

module nibble_add_scheduler #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [4*NIBBLES-1:0] req0_a,
  input  logic [4*NIBBLES-1:0] req0_b,
  input  logic                 req0_cin,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [4*NIBBLES-1:0] req1_a,
  input  logic [4*NIBBLES-1:0] req1_b,
  input  logic                 req1_cin,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [4*NIBBLES-1:0] res_sum,
  output logic                 res_cout,
  output logic                 res_id
);
  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic          c;
  logic          owner;
  logic          last;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  s_q;

  logic          grant0;
  logic          grant1;
  logic [3:0]    nib_a;
  logic [3:0]    nib_b;
  logic [3:0]    add_sum;
  logic          add_cout;

  // Ties go to the requester that was not served last; ready is masked in reset.
  always_comb begin
    grant0     = req0_valid && (!req1_valid || last);
    grant1     = req1_valid && (!req0_valid || !last);
    req0_ready = rst_n && (state == IDLE) && grant0;
    req1_ready = rst_n && (state == IDLE) && grant1;
  end

  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int unsigned n = 0; n < NIBBLES; n++) begin
      if (idx == IW'(n)) begin
        nib_a = a_q[n*4 +: 4];
        nib_b = b_q[n*4 +: 4];
      end
    end
  end

  parallel_adder u_adder (
    .in1      (nib_a),
    .in2      (nib_b),
    .carry_in (c),
    .sum      (add_sum),
    .carry_out(add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      c     <= 1'b0;
      owner <= 1'b0;
      last  <= 1'b1;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            a_q   <= req1_ready ? req1_a   : req0_a;
            b_q   <= req1_ready ? req1_b   : req0_b;
            c     <= req1_ready ? req1_cin : req0_cin;
            owner <= req1_ready;
            last  <= req1_ready;
            idx   <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          for (int unsigned n = 0; n < NIBBLES; n++) begin
            if (idx == IW'(n)) s_q[n*4 +: 4] <= add_sum;
          end
          c <= add_cout;
          if (idx == IW'(NIBBLES - 1)) state <= DONE;
          else                         idx   <= idx + 1'b1;
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign res_valid = (state == DONE);
  assign res_sum   = s_q;
  assign res_cout  = c;
  assign res_id    = owner;
endmodule

// File: tb/tb_nibble_add_scheduler.sv
// Bench for nibble_add_scheduler: vector table plus scoreboard-checked
// arbitration, backpressure and mid-operation reset sequences.

module tb_nibble_add_scheduler;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_cin;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req1_a, req1_b;
  logic         res_valid, res_ready, res_cout, res_id;
  logic [W-1:0] res_sum;

  nibble_add_scheduler #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_cin(req1_cin),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_cout(res_cout), .res_id(res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic         id;
    logic [W-1:0] sum;
    logic         cout;
  } res_t;

  res_t sb[$];
  logic id_log[$];

  function automatic res_t model(input logic id, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic cin);
    res_t r;
    logic [W:0] t;
    t = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    r.id = id; r.sum = t[W-1:0]; r.cout = t[W];
    return r;
  endfunction

  // Scoreboard: push at the handshake, pop at the result transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      chk("ready_exclusive", 32'(req0_ready & req1_ready), 32'd0);
      if (req0_valid && req0_ready) sb.push_back(model(1'b0, req0_a, req0_b, req0_cin));
      if (req1_valid && req1_ready) sb.push_back(model(1'b1, req1_a, req1_b, req1_cin));
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: result id=%0d sum=0x%0h with nothing expected", res_id, res_sum);
        end else begin
          res_t e;
          e = sb.pop_front();
          chk("sb_sum",  32'(res_sum),  32'(e.sum));
          chk("sb_cout", 32'(res_cout), 32'(e.cout));
          chk("sb_id",   32'(res_id),   32'(e.id));
          id_log.push_back(res_id);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         id;
    logic [W-1:0] a, b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    int           bp;
  } vec_t;

  vec_t vecs[7];

  function automatic logic rdy(input logic id);
    return id ? req1_ready : req0_ready;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input vec_t v);
    int k;
    int lat;
    if (v.id) begin
      req1_a = v.a; req1_b = v.b; req1_cin = v.cin; req1_valid = 1'b1;
    end else begin
      req0_a = v.a; req0_b = v.b; req0_cin = v.cin; req0_valid = 1'b1;
    end
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rdy(v.id)) break;
    end
    chk("grant_timeout", 32'(k < 20), 32'd1);
    chk("loser_ready", 32'(rdy(!v.id)), 32'd0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = (v.bp == 0);
    for (lat = 1; lat < 40; lat++) begin
      @(negedge clk);
      if (res_valid) break;
      chk("ready_low_add", 32'(req0_ready | req1_ready), 32'd0);
    end
    chk("latency", 32'(lat), 32'(N + 1));
    chk("vec_sum",  32'(res_sum),  32'(v.sum));
    chk("vec_cout", 32'(res_cout), 32'(v.cout));
    chk("vec_id",   32'(res_id),   32'(v.id));
    if (v.bp > 0) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      repeat (v.bp) begin
        @(negedge clk);
        chk("bp_valid", 32'(res_valid), 32'd1);
        chk("bp_sum",   32'(res_sum),   32'(v.sum));
        chk("bp_cout",  32'(res_cout),  32'(v.cout));
        chk("bp_id",    32'(res_id),    32'(v.id));
        chk("bp_ready", 32'(req0_ready | req1_ready), 32'd0);
      end
      tick();
      res_ready  = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
    end
    tick();
    @(negedge clk);
    chk("valid_drop", 32'(res_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{1'b0, 16'h0003, 16'h000D, 1'b0, 16'h0010, 1'b0, 0};
    vecs[1] = '{1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0};
    vecs[2] = '{1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 0};
    vecs[3] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 0};
    vecs[4] = '{1'b1, 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 0};
    vecs[5] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0};
    vecs[6] = '{1'b1, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 5};

    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h1111; req0_b = 16'h2222; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h3333; req1_b = 16'h4444; req1_cin = 1'b0;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready0",    32'(req0_ready), 32'd0);
    chk("rst_ready1",    32'(req1_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid),  32'd0);
    chk("rst_res_sum",   32'(res_sum),    32'd0);
    chk("rst_res_cout",  32'(res_cout),   32'd0);
    chk("rst_res_id",    32'(res_id),     32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) do_op(vecs[i]);

    // Arbitration: both requesters continuously valid from reset.
    do_reset();
    id_log.delete();
    res_ready  = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int cyc = 0; cyc < 150 && id_log.size() < 6; cyc++) begin
      logic g0, g1;
      @(negedge clk);
      g0 = req0_ready;
      g1 = req1_ready;
      tick();
      if (g0) begin req0_a = 16'($urandom); req0_b = 16'($urandom); req0_cin = 1'($urandom); end
      if (g1) begin req1_a = 16'($urandom); req1_b = 16'($urandom); req1_cin = 1'($urandom); end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("arb_count", 32'(id_log.size() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < id_log.size(); i++)
      chk($sformatf("arb_id_%0d", i), 32'(id_log[i]), 32'(i % 2));
    for (int cyc = 0; cyc < 30 && (sb.size() != 0 || res_valid); cyc++) tick();

    // Reset while req1's operation is at nibble 2.
    req1_a = 16'h00FF; req1_b = 16'h0011; req1_cin = 1'b0; req1_valid = 1'b1;
    begin
      int k;
      for (k = 0; k < 20; k++) begin
        @(negedge clk);
        if (req1_ready) break;
      end
      chk("rma_grant", 32'(k < 20), 32'd1);
    end
    tick();
    req1_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    req0_a = 16'hA5A5; req0_b = 16'h5A5B; req0_cin = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rma_valid",  32'(res_valid),  32'd0);
    chk("rma_sum",    32'(res_sum),    32'd0);
    chk("rma_cout",   32'(res_cout),   32'd0);
    chk("rma_id",     32'(res_id),     32'd0);
    chk("rma_ready0", 32'(req0_ready), 32'd0);
    chk("rma_ready1", 32'(req1_ready), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rma_no_valid", 32'(res_valid), 32'd0);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rma_first_grant0", 32'(req0_ready), 32'd1);
    chk("rma_first_grant1", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int cyc = 0; cyc < 30 && (sb.size() != 0 || res_valid); cyc++) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
